// File: rtl/line_setup_ctrl.sv
// Line command sequencer: Bresenham setup over fixed cycles, then launches the
// fragment generator, frames its framebuffer enable, and supervises completion.
module line_setup_ctrl #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_x0,
  input  logic [WIDTH-1:0] cmd_y0,
  input  logic [WIDTH-1:0] cmd_x1,
  input  logic [WIDTH-1:0] cmd_y1,
  input  logic             cmd_r,
  input  logic             cmd_g,
  input  logic             cmd_b,
  input  logic             abort,
  output logic             fg_start,
  output logic             fg_en_fb,
  output logic             fg_clear,
  output logic             fg_steep,
  output logic             fg_red,
  output logic             fg_green,
  output logic             fg_blue,
  output logic [WIDTH-1:0] fg_deltax,
  output logic [WIDTH-1:0] fg_deltay,
  output logic [WIDTH-1:0] fg_ystep,
  output logic [WIDTH-1:0] fg_x0,
  output logic [WIDTH-1:0] fg_y0,
  output logic [WIDTH-1:0] fg_x_min,
  output logic [WIDTH-1:0] fg_x_max,
  input  logic             fg_finish,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ABS, S_SWAP, S_ORDER, S_ISSUE, S_DRAW, S_DONE
  } state_e;

  // One spare bit so the 2^WIDTH+3 load value fits.
  localparam int              WD_W    = WIDTH + 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((1 << WIDTH) + 3);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x0_q, y0_q, x1_q, y1_q;
  logic [WIDTH-1:0]  x0_d, y0_d, x1_d, y1_d;
  logic              steep_q, steep_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic              fg_steep_q, fg_steep_d;
  logic              fg_red_q, fg_red_d, fg_green_q, fg_green_d, fg_blue_q, fg_blue_d;
  logic [WIDTH-1:0]  fg_deltax_q, fg_deltax_d, fg_deltay_q, fg_deltay_d;
  logic [WIDTH-1:0]  fg_ystep_q, fg_ystep_d, fg_x0_q, fg_x0_d, fg_y0_q, fg_y0_d;
  logic [WIDTH-1:0]  fg_x_min_q, fg_x_min_d, fg_x_max_q, fg_x_max_d;

  logic [WIDTH-1:0]  adx, ady;
  logic              swap_ends;
  logic [WIDTH-1:0]  ox0, oy0, ox1, oy1, ody;
  logic              abort_act;

  // Setup arithmetic on the working endpoints; each state consumes its slice.
  always_comb begin
    adx       = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    ady       = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    swap_ends = x0_q > x1_q;
    ox0       = swap_ends ? x1_q : x0_q;
    oy0       = swap_ends ? y1_q : y0_q;
    ox1       = swap_ends ? x0_q : x1_q;
    oy1       = swap_ends ? y0_q : y1_q;
    ody       = (oy1 >= oy0) ? (oy1 - oy0) : (oy0 - oy1);
    abort_act = abort && (state_q != S_IDLE);
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    steep_d     = steep_q;
    wdog_d      = wdog_q;
    fg_steep_d  = fg_steep_q;
    fg_red_d    = fg_red_q;
    fg_green_d  = fg_green_q;
    fg_blue_d   = fg_blue_q;
    fg_deltax_d = fg_deltax_q;
    fg_deltay_d = fg_deltay_q;
    fg_ystep_d  = fg_ystep_q;
    fg_x0_d     = fg_x0_q;
    fg_y0_d     = fg_y0_q;
    fg_x_min_d  = fg_x_min_q;
    fg_x_max_d  = fg_x_max_q;
    cmd_ready   = 1'b0;
    fg_start    = 1'b0;
    fg_en_fb    = 1'b0;
    fg_clear    = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          x0_d       = cmd_x0;
          y0_d       = cmd_y0;
          x1_d       = cmd_x1;
          y1_d       = cmd_y1;
          fg_red_d   = cmd_r;
          fg_green_d = cmd_g;
          fg_blue_d  = cmd_b;
          state_d    = S_ABS;
        end
      end
      S_ABS: begin
        steep_d = ady > adx;
        state_d = S_SWAP;
      end
      S_SWAP: begin
        if (steep_q) begin
          x0_d = y0_q;
          y0_d = x0_q;
          x1_d = y1_q;
          y1_d = x1_q;
        end
        state_d = S_ORDER;
      end
      S_ORDER: begin
        // Outputs stay untouched if the command is cancelled before launch.
        if (!abort_act) begin
          fg_steep_d  = steep_q;
          fg_deltax_d = ox1 - ox0;
          fg_deltay_d = ody;
          fg_ystep_d  = (oy0 < oy1) ? WIDTH'(1) : '1;
          fg_x0_d     = ox0;
          fg_y0_d     = oy0;
          fg_x_min_d  = ox0;
          fg_x_max_d  = ox1;
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        fg_start = 1'b1;
        wdog_d   = WD_LOAD;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        fg_en_fb = 1'b1;
        wdog_d   = wdog_q - WD_W'(1);
        if (fg_finish) begin
          state_d = S_DONE;
        end else if (wdog_q == WD_W'(1)) begin
          err      = 1'b1;
          fg_clear = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        fg_clear = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancellation outranks both completion and watchdog expiry.
    if (abort_act) begin
      done     = 1'b0;
      err      = 1'b0;
      fg_clear = 1'b1;
      state_d  = S_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      steep_q     <= 1'b0;
      wdog_q      <= '0;
      fg_steep_q  <= 1'b0;
      fg_red_q    <= 1'b0;
      fg_green_q  <= 1'b0;
      fg_blue_q   <= 1'b0;
      fg_deltax_q <= '0;
      fg_deltay_q <= '0;
      fg_ystep_q  <= '0;
      fg_x0_q     <= '0;
      fg_y0_q     <= '0;
      fg_x_min_q  <= '0;
      fg_x_max_q  <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      steep_q     <= steep_d;
      wdog_q      <= wdog_d;
      fg_steep_q  <= fg_steep_d;
      fg_red_q    <= fg_red_d;
      fg_green_q  <= fg_green_d;
      fg_blue_q   <= fg_blue_d;
      fg_deltax_q <= fg_deltax_d;
      fg_deltay_q <= fg_deltay_d;
      fg_ystep_q  <= fg_ystep_d;
      fg_x0_q     <= fg_x0_d;
      fg_y0_q     <= fg_y0_d;
      fg_x_min_q  <= fg_x_min_d;
      fg_x_max_q  <= fg_x_max_d;
    end
  end

  assign busy      = state_q != S_IDLE;
  assign fg_steep  = fg_steep_q;
  assign fg_red    = fg_red_q;
  assign fg_green  = fg_green_q;
  assign fg_blue   = fg_blue_q;
  assign fg_deltax = fg_deltax_q;
  assign fg_deltay = fg_deltay_q;
  assign fg_ystep  = fg_ystep_q;
  assign fg_x0     = fg_x0_q;
  assign fg_y0     = fg_y0_q;
  assign fg_x_min  = fg_x_min_q;
  assign fg_x_max  = fg_x_max_q;

endmodule

// File: tb/tb_line_setup_ctrl.sv
// Scoreboard bench for line_setup_ctrl: a driver pushes expected launches and
// endings from a geometric reference model; a monitor pops and compares them.
module tb_line_setup_ctrl;

  localparam int W  = 13;
  localparam int WD = (1 << W) + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic         cmd_r, cmd_g, cmd_b, abort;
  logic         fg_start, fg_en_fb, fg_clear, fg_steep, fg_red, fg_green, fg_blue;
  logic [W-1:0] fg_deltax, fg_deltay, fg_ystep, fg_x0, fg_y0, fg_x_min, fg_x_max;
  logic         fg_finish, busy, done, err;

  line_setup_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .abort(abort),
    .fg_start(fg_start), .fg_en_fb(fg_en_fb), .fg_clear(fg_clear),
    .fg_steep(fg_steep), .fg_red(fg_red), .fg_green(fg_green), .fg_blue(fg_blue),
    .fg_deltax(fg_deltax), .fg_deltay(fg_deltay), .fg_ystep(fg_ystep),
    .fg_x0(fg_x0), .fg_y0(fg_y0), .fg_x_min(fg_x_min), .fg_x_max(fg_x_max),
    .fg_finish(fg_finish), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic steep;
    int   dx, dy, ys, x0, y0, xmin, xmax;
    logic r, g, b;
    int   cyc;
  } setup_t;

  typedef enum int {E_DONE, E_ERR, E_ABORT} end_kind_e;

  typedef struct {
    end_kind_e kind;
    int        cyc;
    int        en;
  } end_t;

  setup_t setup_q[$];
  end_t   end_q[$];
  int     compared   = 0;
  int     mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Geometric reference: make the line shallow by transposing, then walk it left to right.
  function automatic setup_t model(input int ax0, input int ay0, input int ax1, input int ay1,
                                   input logic r, input logic g, input logic b, input int at);
    setup_t s;
    int adx, ady, px0, py0, px1, py1, t;
    adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    s.steep = ady > adx;
    if (s.steep) begin
      px0 = ay0; py0 = ax0; px1 = ay1; py1 = ax1;
    end else begin
      px0 = ax0; py0 = ay0; px1 = ax1; py1 = ay1;
    end
    if (px0 > px1) begin
      t = px0; px0 = px1; px1 = t;
      t = py0; py0 = py1; py1 = t;
    end
    s.dx   = px1 - px0;
    s.dy   = (py1 > py0) ? py1 - py0 : py0 - py1;
    s.ys   = (py0 < py1) ? 1 : (1 << W) - 1;
    s.x0   = px0;
    s.y0   = py0;
    s.xmin = px0;
    s.xmax = px1;
    s.r = r; s.g = g; s.b = b;
    s.cyc  = at;
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_ctl"}, {busy, done, err, fg_start, fg_en_fb, fg_clear}, 0);
    check({tag, "_flags"}, {fg_steep, fg_red, fg_green, fg_blue, fg_deltax, fg_deltay, fg_ystep}, 0);
    check({tag, "_coords"}, {fg_x0, fg_y0, fg_x_min, fg_x_max}, 0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < bound);
    if (!cmd_ready) check("idle_wait", cmd_ready, 1);
  endtask

  // k: finish offset after DRAW entry (-1 = never); ab: abort offset from A (-1 = none).
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input logic r, input logic g, input logic b,
                         input int k, input int ab, input bit hold, input bit rst_in_swap);
    int   acc, f_off, last, en;
    end_t e;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_x0 = W'(x0); cmd_y0 = W'(y0); cmd_x1 = W'(x1); cmd_y1 = W'(y1);
    cmd_r = r; cmd_g = g; cmd_b = b;
    @(negedge clk);
    check("ready_at_accept", cmd_ready, 1);
    acc = cyc;
    if (rst_in_swap) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_swap");
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    f_off = (k < 0) ? -1 : 5 + k;
    if (ab < 0) begin
      setup_q.push_back(model(x0, y0, x1, y1, r, g, b, acc + 4));
      if (k >= 0) begin
        e.kind = E_DONE; e.cyc = acc + f_off + 1; e.en = k + 1;
      end else begin
        e.kind = E_ERR; e.cyc = acc + 4 + WD; e.en = WD;
      end
    end else begin
      if (ab >= 4) setup_q.push_back(model(x0, y0, x1, y1, r, g, b, acc + 4));
      if (ab <= 4) en = 0;
      else if (f_off >= 0 && ab == f_off + 1) en = k + 1;
      else en = ab - 4;
      e.kind = E_ABORT; e.cyc = acc + ab; e.en = en;
    end
    end_q.push_back(e);

    last = (k < 0) ? ((ab < 0) ? 0 : ab) : f_off + 1;
    for (int t = 1; t <= last; t++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      abort     = (t == ab);
      // Pulses before DRAW must be ignored by the controller.
      fg_finish = (t == f_off) || (hold && t >= 5) || (t <= 4 && $urandom_range(0, 1) == 1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    fg_finish = 1'b0;
    wait_idle(WD + 100);
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT launches or ends a command.
  initial begin
    int     en_seen  = 0;
    bit     post_end = 1'b0;
    setup_t s;
    end_t   e;
    logic [2:0] exp_vec;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_seen  = 0;
        post_end = 1'b0;
      end else begin
        if (post_end) begin
          check("ready_after_end", {cmd_ready, busy}, 2'b10);
          post_end = 1'b0;
        end
        if (fg_en_fb) en_seen++;
        if (fg_start) begin
          if (setup_q.size() == 0) begin
            check("unexpected_start", fg_start, 0);
          end else begin
            s = setup_q.pop_front();
            check("start_cycle", cyc, s.cyc);
            check("steep", fg_steep, s.steep);
            check("deltax", fg_deltax, s.dx);
            check("deltay", fg_deltay, s.dy);
            check("ystep", fg_ystep, s.ys);
            check("x0", fg_x0, s.x0);
            check("y0", fg_y0, s.y0);
            check("x_min", fg_x_min, s.xmin);
            check("x_max", fg_x_max, s.xmax);
            check("colour", {fg_red, fg_green, fg_blue}, {s.r, s.g, s.b});
          end
          en_seen = 0;
        end
        if (done || err || fg_clear) begin
          if (end_q.size() == 0) begin
            check("unexpected_end", {done, err, fg_clear}, 0);
          end else begin
            e = end_q.pop_front();
            case (e.kind)
              E_DONE:  exp_vec = 3'b101;
              E_ERR:   exp_vec = 3'b011;
              default: exp_vec = 3'b001;
            endcase
            check("end_kind", {done, err, fg_clear}, exp_vec);
            check("end_cycle", cyc, e.cyc);
            check("en_fb_cycles", en_seen, e.en);
            check("busy_at_end", busy, 1);
          end
          en_seen  = 0;
          post_end = 1'b1;
        end
      end
    end
  end

  initial begin
    int x0, y0, x1, y1, k, ab, lim;
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; fg_finish = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    cmd_r = 1'b0; cmd_g = 1'b0; cmd_b = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_cmd(2, 3, 10, 6, 1, 0, 1, 3, -1, 0, 0);           // shallow
    run_cmd(5, 20, 3, 4, 0, 1, 0, 0, -1, 0, 0);           // steep reversed
    run_cmd(0, 9, 9, 0, 1, 1, 1, 7, -1, 0, 0);            // descending, equal magnitudes
    run_cmd(7, 7, 7, 7, 0, 0, 1, 0, -1, 1, 0);            // point, finish held
    run_cmd(1, 2, 30, 40, 1, 0, 0, 4, 9, 0, 0);           // abort with finish in DRAW
    run_cmd(100, 50, 20, 60, 0, 1, 1, 2, 8, 0, 0);        // abort in DONE
    run_cmd(3, 3, 9, 1, 1, 1, 0, 2, 1, 0, 0);             // abort in ABS
    run_cmd(3, 3, 9, 1, 1, 1, 0, 2, 3, 0, 0);             // abort in ORDER
    run_cmd(8, 1, 0, 5, 0, 0, 1, 2, 4, 0, 0);             // abort in ISSUE
    run_cmd(0, 0, 8191, 8191, 1, 0, 1, 1, -1, 0, 0);      // full-range diagonal
    run_cmd(8191, 0, 0, 8191, 0, 1, 0, 1, -1, 0, 0);
    run_cmd(4000, 17, 4001, 8000, 1, 1, 1, 5, -1, 0, 0);

    @(posedge clk); #1 abort = 1'b1;                      // ignored while idle
    @(posedge clk); #1 abort = 1'b0;
    repeat (2) @(posedge clk);

    run_cmd(11, 12, 40, 13, 1, 0, 1, 3, -1, 0, 1);        // async reset in SWAP
    run_cmd(6, 1, 2, 9, 1, 1, 0, 1, -1, 0, 0);            // recovers after reset
    run_cmd(10, 10, 20, 25, 0, 1, 1, -1, -1, 0, 0);       // watchdog expiry

    for (int n = 0; n < 40; n++) begin
      lim = ($urandom_range(0, 1) == 1) ? (1 << W) - 1 : 31;
      x0 = $urandom_range(0, lim); y0 = $urandom_range(0, lim);
      x1 = $urandom_range(0, lim); y1 = $urandom_range(0, lim);
      k  = $urandom_range(0, 15);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6 + k) : -1;
      run_cmd(x0, y0, x1, y1, 1'($urandom), 1'($urandom), 1'($urandom), k, ab, 0, 0);
    end

    repeat (4) @(posedge clk);
    check("pending_expectations", setup_q.size() + end_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/line_setup_ctrl.md
# line_setup_ctrl

Sequencer in front of `fragment_generator`. Accepts one line command (two endpoints plus a 1-bit RGB colour) over a valid/ready handshake. Performs the Bresenham setup over fixed cycles: steep test, axis swap, endpoint ordering, deltas and ystep. Then launches the fragment generator, frames its framebuffer-register enable, waits for `finish`, and reports completion or a watchdog timeout.

## Interface
- `WIDTH`, 13, coordinate/delta width; all coordinates unsigned.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller idle; command accepted when `cmd_valid & cmd_ready`.
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1`  in  WIDTH  endpoints.
- `cmd_r`, `cmd_g`, `cmd_b`  in  1  colour.
- `abort`  in  1  synchronous cancel of the command in flight.
- `fg_start`  out  1  one-cycle start pulse to the fragment generator.
- `fg_en_fb`  out  1  drives `en_FB_reg`.
- `fg_clear`  out  1  one-cycle clear pulse; top level ORs it with `rst` into the generator's `rst`.
- `fg_steep`, `fg_red`, `fg_green`, `fg_blue`  out  1  setup results and colour.
- `fg_deltax`, `fg_deltay`, `fg_ystep`, `fg_x0`, `fg_y0`, `fg_x_min`, `fg_x_max`  out  WIDTH  setup results.
- `fg_finish`  in  1  generator's `finish` (last count).
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse on watchdog timeout.

## Operation
- States: IDLE, ABS, SWAP, ORDER, ISSUE, DRAW, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, register endpoints and colour, then go to ABS.
- ABS:
  - Compute adx=|x1-x0| and ady=|y1-y0| as unsigned WIDTH-bit magnitude differences.
  - Set steep = ady > adx (equal gives steep=0).
  - Go to SWAP.
- SWAP:
  - If steep, exchange x↔y in both endpoints.
  - Go to ORDER.
- ORDER:
  - If x0 > x1, exchange the endpoints.
  - Then set deltax=x1-x0 and deltay=|y1-y0|.
  - Set ystep = +1 if y0<y1, else all-ones (−1, two's complement WIDTH).
  - Set x_min=x0, x_max=x1, fg_x0=x0, fg_y0=y0.
  - Go to ISSUE.
- ISSUE:
  - `fg_start`=1 for exactly this cycle.
  - Load watchdog with 2^WIDTH+3.
  - Go to DRAW.
- DRAW:
  - `fg_en_fb`=1 every cycle.
  - Watchdog decrements each cycle.
  - On `fg_finish`, go to DONE.
  - On watchdog reaching 0, pulse `err` and `fg_clear`, then go to IDLE.
- DONE:
  - `done`=1 and `fg_clear`=1 for one cycle.
  - Go to IDLE.
- All `fg_*` data outputs are registered and hold stable from ISSUE until the next command's ORDER cycle.
- `fg_red/green/blue` update at acceptance.
- `abort` in any non-IDLE state:
  - Next state is IDLE and `fg_clear` pulses once.
  - No `done` or `err`.
  - `abort` has priority over `fg_finish` and over watchdog expiry in the same cycle.
  - `abort` in IDLE is ignored.
- Degenerate point line (x0=x1, y0=y1): deltax=0, deltay=0, steep=0, ystep=all-ones, x_min=x_max. It is processed normally.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1.
  - All other outputs 0, including all `fg_*` data, `busy`, `done`, `err`.
- Let cycle A be the handshake edge.
  - Setup states: ABS=A+1, SWAP=A+2, ORDER=A+3.
  - `fg_start` is high in cycle A+4; `fg_en_fb` goes high from A+5.
- `fg_finish` sampled high in cycle F gives DONE in F+1 (`done`, `fg_clear` high) and IDLE (`cmd_ready`=1) in F+2.
- `fg_finish` is ignored outside DRAW.
- No back-to-back acceptance: minimum command spacing is 7 cycles.
- `rst` asserted mid-operation: immediate return to reset values with no `done`/`err`; generator is reset via the top-level OR.

## Test plan
- Shallow line, cmd (2,3)->(10,6):
  - steep=0; x_min=2, x_max=10; deltax=8, deltay=3, ystep=1.
  - `fg_start` at A+4; after `fg_finish`, `done` at F+1.
- Steep reversed line, cmd (5,20)->(3,4):
  - steep=1; swapped points (20,5),(4,3), then ordered to (4,3),(20,5).
  - deltax=16, deltay=2, ystep=1; x_min=4, x_max=20, fg_y0=3.
- Descending line, cmd (0,9)->(9,0):
  - adx=ady=9, so steep=0; deltax=9, deltay=9, ystep=13'h1FFF.
- Point line, cmd (7,7)->(7,7):
  - deltax=0, deltay=0; x_min=x_max=7.
  - `fg_finish` held high gives `done` one cycle after DRAW entry.
- `abort` in DRAW together with `fg_finish`:
  - `fg_clear` pulse, no `done`, `cmd_ready`=1 next cycle.
  - Async `rst` in SWAP: all outputs 0 immediately.
- `fg_finish` never asserted (WIDTH=4 build):
  - `err` pulses after exactly 19 DRAW cycles together with `fg_clear`; then IDLE.
